remote_force_receiver: RTL and testbench



---
 rtl/remote_force_receiver_pkg.sv | 33 +++
 rtl/remote_force_receiver_if.sv | 29 ++
 rtl/remote_force_receiver_force_accum_ram.sv | 27 ++
 rtl/remote_force_receiver.sv | 170 +++++++++++++++++
 tb/tb_remote_force_receiver.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_force_receiver_pkg.sv
// Shared widths, packet/force types and receiver FSM states for the force-writeback receiver.
package remote_force_receiver_pkg;

   localparam int FRX_DATA_WIDTH        = 32;
   localparam int FRX_PARTICLE_ID_WIDTH = 7;
   localparam int FRX_NODE_ID_WIDTH     = 6;
   localparam int FRX_CNT_WIDTH         = 16;

   typedef struct packed {
      logic signed [FRX_DATA_WIDTH-1:0] z;
      logic signed [FRX_DATA_WIDTH-1:0] y;
      logic signed [FRX_DATA_WIDTH-1:0] x;
   } force_t;

   typedef struct packed {
      logic [FRX_PARTICLE_ID_WIDTH-1:0] particle_id;
      force_t                           force_val;
   } payload_t;

   typedef struct packed {
      logic [FRX_NODE_ID_WIDTH-1:0] dest_id;
      payload_t                     payload;
   } packet_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } force_rx_state_t;

endpackage

// File: rtl/remote_force_receiver_if.sv
// Packet ingress, iteration control, force readout and counters of the force receiver.
interface remote_force_receiver_if;
   import remote_force_receiver_pkg::*;

   packet_t                            pkt_in;
   logic                               pkt_valid;
   logic                               pkt_ready;
   logic                               clear_start;
   logic                               flush;
   logic                               busy;
   logic                               done;
   logic                               rd_en;
   logic [FRX_PARTICLE_ID_WIDTH-1:0]   rd_addr;
   logic [3*FRX_DATA_WIDTH-1:0]        rd_data;
   logic                               rd_valid;
   logic [FRX_CNT_WIDTH-1:0]           pkt_count;
   logic [FRX_CNT_WIDTH-1:0]           drop_count;

   modport master (
      output pkt_in, pkt_valid, clear_start, flush, rd_en, rd_addr,
      input  pkt_ready, busy, done, rd_data, rd_valid, pkt_count, drop_count
   );

   modport slave (
      input  pkt_in, pkt_valid, clear_start, flush, rd_en, rd_addr,
      output pkt_ready, busy, done, rd_data, rd_valid, pkt_count, drop_count
   );

endinterface

// File: rtl/remote_force_receiver_force_accum_ram.sv
// Simple dual-port force memory: one write port, one read port, 1-cycle registered read,
// old data returned on read-during-write to the same address, no reset.
module force_accum_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [ADDR_W-1:0] ra_i,
   output logic [DATA_W-1:0] rd_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wa_i] <= wd_i;
      end
      rd_q <= mem_q[ra_i];
   end

   assign rd_o = rd_q;

endmodule

// File: rtl/remote_force_receiver.sv
// Force-writeback receiver: accumulates home-cell force packets per particle, 2-stage RMW, 1 pkt/cycle.
// pkt_ready is purely state based (high only in RUN); reads honoured in DONE, data the next cycle.
// FORCE_RX_SATURATE_EN selects clamping lane adds instead of wrap-around.
module remote_force_receiver
   import remote_force_receiver_pkg::*;
#(
   parameter int DATA_WIDTH        = FRX_DATA_WIDTH,
   parameter int PARTICLE_ID_WIDTH = FRX_PARTICLE_ID_WIDTH,
   parameter int NODE_ID_WIDTH     = FRX_NODE_ID_WIDTH,
   parameter int HOME_CELL_ID      = 0,
   parameter int CNT_WIDTH         = FRX_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   remote_force_receiver_if.slave   rx_if
);

   localparam int RAM_W = 3 * DATA_WIDTH;

   force_rx_state_t state_q, state_d;

   logic [PARTICLE_ID_WIDTH-1:0] clr_q;
   logic                         s1_vld_q;
   logic [PARTICLE_ID_WIDTH-1:0] s1_addr_q;
   force_t                       s1_force_q;
   logic                         lw_vld_q;
   logic [PARTICLE_ID_WIDTH-1:0] lw_addr_q;
   force_t                       lw_dat_q;
   logic [CNT_WIDTH-1:0]         pkt_cnt_q;
   logic [CNT_WIDTH-1:0]         drop_cnt_q;
   logic                         rd_vld_q;
   logic [RAM_W-1:0]             rd_hold_q;

   logic                         xfer;
   logic                         hit;
   logic                         miss;
   logic                         enter_clear;
   logic                         ram_we;
   logic [PARTICLE_ID_WIDTH-1:0] ram_wa;
   logic [RAM_W-1:0]             ram_wd;
   logic [PARTICLE_ID_WIDTH-1:0] ram_ra;
   logic [RAM_W-1:0]             ram_rd;
   force_t                       base_dat;
   force_t                       sum_dat;

   function automatic logic [DATA_WIDTH-1:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] s;
      s = a + b;
`ifdef FORCE_RX_SATURATE_EN
      if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1])) begin
         s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`endif
      return s;
   endfunction

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (rx_if.clear_start) state_d = ST_CLEAR;
         ST_CLEAR: if (clr_q == '1)       state_d = ST_RUN;
         ST_RUN:   if (rx_if.flush)       state_d = ST_DRAIN;
         // The last accepted packet is in S1 during DRAIN and retires on this edge.
         ST_DRAIN:                        state_d = ST_DONE;
         ST_DONE:  if (rx_if.clear_start) state_d = ST_CLEAR;
         default:                         state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign xfer        = rx_if.pkt_valid && (state_q == ST_RUN);
   assign hit         = xfer && (rx_if.pkt_in.dest_id == NODE_ID_WIDTH'(HOME_CELL_ID));
   assign miss        = xfer && !hit;
   assign enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);

   // Forward the last write when S1 re-reads the address the RAM is still returning stale data for.
   always_comb begin
      base_dat = force_t'(ram_rd);
      if (lw_vld_q && (lw_addr_q == s1_addr_q)) base_dat = lw_dat_q;
      sum_dat.x = lane_add(base_dat.x, s1_force_q.x);
      sum_dat.y = lane_add(base_dat.y, s1_force_q.y);
      sum_dat.z = lane_add(base_dat.z, s1_force_q.z);
   end

   always_comb begin
      ram_we = s1_vld_q;
      ram_wa = s1_addr_q;
      ram_wd = RAM_W'(sum_dat);
      if (state_q == ST_CLEAR) begin
         ram_we = 1'b1;
         ram_wa = clr_q;
         ram_wd = '0;
      end
      ram_ra = (state_q == ST_DONE) ? rx_if.rd_addr : rx_if.pkt_in.payload.particle_id;
   end

   force_accum_ram #(
      .ADDR_W (PARTICLE_ID_WIDTH),
      .DATA_W (RAM_W)
   ) u_ram (
      .clk  (clk),
      .we_i (ram_we),
      .wa_i (ram_wa),
      .wd_i (ram_wd),
      .ra_i (ram_ra),
      .rd_o (ram_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_force_q <= '0;
         lw_vld_q   <= 1'b0;
         lw_addr_q  <= '0;
         lw_dat_q   <= '0;
      end else begin
         clr_q      <= (state_q == ST_CLEAR) ? clr_q + 1'b1 : '0;
         s1_vld_q   <= hit;
         s1_addr_q  <= rx_if.pkt_in.payload.particle_id;
         s1_force_q <= rx_if.pkt_in.payload.force_val;
         if (state_q == ST_CLEAR) begin
            lw_vld_q <= 1'b0;
         end else if (s1_vld_q) begin
            lw_vld_q  <= 1'b1;
            lw_addr_q <= s1_addr_q;
            lw_dat_q  <= sum_dat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else if (enter_clear) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (hit  && (pkt_cnt_q  != '1)) pkt_cnt_q  <= pkt_cnt_q + 1'b1;
         if (miss && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_hold_q <= '0;
      end else begin
         rd_vld_q <= rx_if.rd_en && (state_q == ST_DONE);
         if (rd_vld_q) rd_hold_q <= ram_rd;
      end
   end

   assign rx_if.pkt_ready  = (state_q == ST_RUN);
   assign rx_if.busy       = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign rx_if.done       = (state_q == ST_DONE);
   assign rx_if.rd_valid   = rd_vld_q;
   assign rx_if.rd_data    = rd_vld_q ? ram_rd : rd_hold_q;
   assign rx_if.pkt_count  = pkt_cnt_q;
   assign rx_if.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_remote_force_receiver.sv
// Directed bench for remote_force_receiver: clear, accumulate, drop, wrap/saturate, reset mid-run.
module tb_remote_force_receiver;
   import remote_force_receiver_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   remote_force_receiver_if bus ();

   remote_force_receiver #(
      .DATA_WIDTH        (32),
      .PARTICLE_ID_WIDTH (7),
      .NODE_ID_WIDTH     (6),
      .HOME_CELL_ID      (0),
      .CNT_WIDTH         (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pkt_in      = '0;
      bus.pkt_valid   = 1'b0;
      bus.clear_start = 1'b0;
      bus.flush       = 1'b0;
      bus.rd_en       = 1'b0;
      bus.rd_addr     = '0;
   endtask

   task automatic drive_pkt(input logic [5:0] dest, input logic [6:0] pid,
                            input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      bus.pkt_valid                    = 1'b1;
      bus.pkt_in.dest_id               = dest;
      bus.pkt_in.payload.particle_id   = pid;
      bus.pkt_in.payload.force_val.x   = x;
      bus.pkt_in.payload.force_val.y   = y;
      bus.pkt_in.payload.force_val.z   = z;
      tick();
      bus.pkt_valid = 1'b0;
   endtask

   // Pulses clear_start and returns the number of cycles pkt_ready stayed low.
   task automatic start_iteration(output int low_cycles);
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      low_cycles = 0;
      while (!bus.pkt_ready && low_cycles < 300) begin
         low_cycles++;
         tick();
      end
   endtask

   task automatic do_read(input logic [6:0] addr, output logic vld, output logic [95:0] dat);
      bus.rd_en   = 1'b1;
      bus.rd_addr = addr;
      tick();
      bus.rd_en = 1'b0;
      vld = bus.rd_valid;
      dat = bus.rd_data;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.pkt_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b busy=%b done=%b rd_valid=%b, required all 0",
                  bus.pkt_ready, bus.busy, bus.done, bus.rd_valid);
      end
      checks++;
      if (bus.rd_data !== 96'h0 || bus.pkt_count !== 16'd0 || bus.drop_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: rd_data=%h pkt=%0d drop=%0d, required 0/0/0",
                  bus.rd_data, bus.pkt_count, bus.drop_count);
      end
   endtask

   task automatic test_idle_hold();
      logic seen_ready;
      seen_ready = 1'b0;
      bus.pkt_valid = 1'b1;
      bus.pkt_in    = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.pkt_ready !== 1'b0) seen_ready = 1'b1;
      end
      bus.pkt_valid = 1'b0;
      checks++;
      if (seen_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: pkt_ready went high without clear_start, required 0");
      end
      checks++;
      if (bus.pkt_count !== 16'd0) begin
         errors++;
         $display("FAIL idle_count: pkt_count=%0d, required 0", bus.pkt_count);
      end
   endtask

   task automatic test_clear();
      int low;
      logic vld;
      logic [95:0] dat;
      bus.pkt_valid = 1'b0;
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL clear_busy: busy=%b, required 1", bus.busy);
      end
      low = 1;
      tick();
      while (!bus.pkt_ready && low < 300) begin
         low++;
         tick();
      end
      checks++;
      if (low !== 128) begin
         errors++;
         $display("FAIL clear_len: pkt_ready low %0d cycles, required 128", low);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL clear_done: done=%b two cycles after flush, required 1", bus.done);
      end
      for (int a = 0; a < 128; a++) begin
         do_read(7'(a), vld, dat);
         checks++;
         if (vld !== 1'b1 || dat !== 96'h0) begin
            errors++;
            $display("FAIL clear_read[%0d]: valid=%b data=%h, required 1/0", a, vld, dat);
         end
      end
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_pulse: rd_valid=%b with no read, required 0", bus.rd_valid);
      end
   endtask

   task automatic test_accumulate();
      int low;
      logic vld;
      logic [95:0] dat;
      start_iteration(low);
      checks++;
      if (low !== 128) begin
         errors++;
         $display("FAIL accum_clear_len: %0d, required 128", low);
      end
      checks++;
      if (bus.pkt_count !== 16'd0 || bus.drop_count !== 16'd0) begin
         errors++;
         $display("FAIL accum_cnt_zero: pkt=%0d drop=%0d, required 0/0", bus.pkt_count, bus.drop_count);
      end
      drive_pkt(6'd0, 7'd5, 32'd1, 32'd0, 32'd0);
      bus.pkt_valid = 1'b1;
      drive_pkt(6'd0, 7'd5, 32'd2, 32'd0, 32'd0);
      bus.pkt_valid = 1'b1;
      drive_pkt(6'd0, 7'd5, 32'd3, 32'd0, 32'd0);
      drive_pkt(6'd1, 7'd5, 32'd100, 32'd100, 32'd100);
      checks++;
      if (bus.drop_count !== 16'd1) begin
         errors++;
         $display("FAIL drop_count: %0d, required 1", bus.drop_count);
      end
      // Packet coinciding with flush must still be accumulated.
      bus.flush = 1'b1;
      drive_pkt(6'd0, 7'd7, 32'd9, 32'h0000_0010, 32'hFFFF_FFFF);
      bus.flush = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL accum_done: done=%b two cycles after flush, required 1", bus.done);
      end
      checks++;
      if (bus.pkt_count !== 16'd4) begin
         errors++;
         $display("FAIL pkt_count: %0d, required 4", bus.pkt_count);
      end
      do_read(7'd5, vld, dat);
      checks++;
      if (vld !== 1'b1 || dat !== {32'd0, 32'd0, 32'd6}) begin
         errors++;
         $display("FAIL read_p5: valid=%b data=%h, required 1/%h", vld, dat, {32'd0, 32'd0, 32'd6});
      end
      tick();
      tick();
      checks++;
      if (bus.rd_data !== {32'd0, 32'd0, 32'd6}) begin
         errors++;
         $display("FAIL rd_hold: data=%h, required %h", bus.rd_data, {32'd0, 32'd0, 32'd6});
      end
      do_read(7'd7, vld, dat);
      checks++;
      if (vld !== 1'b1 || dat !== {32'hFFFF_FFFF, 32'h0000_0010, 32'd9}) begin
         errors++;
         $display("FAIL read_p7: valid=%b data=%h, required 1/%h", vld, dat,
                  {32'hFFFF_FFFF, 32'h0000_0010, 32'd9});
      end
      do_read(7'd6, vld, dat);
      checks++;
      if (dat !== 96'h0) begin
         errors++;
         $display("FAIL read_p6: data=%h, required 0", dat);
      end
   endtask

   task automatic test_overflow();
      int low;
      logic vld;
      logic [95:0] dat;
      logic [95:0] exp;
`ifdef FORCE_RX_SATURATE_EN
      exp = {32'h8000_0000, 32'hFFFF_FFF8, 32'h7FFF_FFFF};
`else
      exp = {32'h7FFF_FFFF, 32'hFFFF_FFF8, 32'h8000_0000};
`endif
      start_iteration(low);
      checks++;
      if (bus.pkt_count !== 16'd0 || bus.drop_count !== 16'd0) begin
         errors++;
         $display("FAIL ovf_cnt_zero: pkt=%0d drop=%0d, required 0/0", bus.pkt_count, bus.drop_count);
      end
      bus.pkt_valid = 1'b1;
      drive_pkt(6'd0, 7'd9, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000);
      bus.pkt_valid = 1'b1;
      drive_pkt(6'd0, 7'd9, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000);
      bus.pkt_valid = 1'b1;
      drive_pkt(6'd0, 7'd9, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL ovf_done: done=%b, required 1", bus.done);
      end
      do_read(7'd9, vld, dat);
      checks++;
      if (vld !== 1'b1 || dat !== exp) begin
         errors++;
         $display("FAIL ovf_read: valid=%b data=%h, required 1/%h", vld, dat, exp);
      end
   endtask

   task automatic test_reset_mid_run();
      int low;
      start_iteration(low);
      for (int i = 0; i < 10; i++) begin
         drive_pkt(6'd0, 7'(i + 20), 32'(i + 1), 32'd0, 32'd0);
      end
      checks++;
      if (bus.pkt_count !== 16'd10 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: pkt=%0d busy=%b, required 10/1", bus.pkt_count, bus.busy);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.pkt_ready !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: busy=%b ready=%b done=%b, required 0/0/0",
                  bus.busy, bus.pkt_ready, bus.done);
      end
      checks++;
      if (bus.pkt_count !== 16'd0 || bus.drop_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_cnt: pkt=%0d drop=%0d, required 0/0", bus.pkt_count, bus.drop_count);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.pkt_ready !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: ready=%b busy=%b, required 0/0", bus.pkt_ready, bus.busy);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_idle_hold();
      test_clear();
      test_accumulate();
      test_overflow();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
